// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_conditioner
//  Purpose  : Synchronises, debounces and qualifies three line-follower
//             optical sensors. Provides a warm-up valid flag, a one-cycle
//             change strobe and a "line lost" flag for the robot controller.
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 100000,
    parameter int         LOST_CYCLES     = 5000000,
    parameter logic [2:0] LOST_PATTERN    = 3'b000
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_l_raw,
    input  logic sensor_m_raw,
    input  logic sensor_r_raw,
    output logic sensor_l,
    output logic sensor_m,
    output logic sensor_r,
    output logic sensors_valid,
    output logic sensors_changed,
    output logic line_lost
);

    // Debounce counters only ever need to reach DEBOUNCE_CYCLES-1.
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    // Warm-up counter must hold DEBOUNCE_CYCLES+1 (the value seen on the
    // edge that raises sensors_valid).
    localparam int c_WARM_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int c_LOST_W = $clog2(LOST_CYCLES + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_WARM_W-1:0] c_WARM_LAST = c_WARM_W'(DEBOUNCE_CYCLES + 1);
    localparam logic [c_LOST_W-1:0] c_LOST_MAX  = c_LOST_W'(LOST_CYCLES);

    // Bit order everywhere is {l, m, r}.
    logic [2:0]          w_raw;
    logic [2:0]          sync1_q;
    logic [2:0]          sync2_q;
    logic [2:0]          db_q;
    logic [2:0]          db_d;
    logic [c_DB_W-1:0]   db_cnt_q [3];
    logic [c_DB_W-1:0]   db_cnt_d [3];
    logic [c_WARM_W-1:0] warm_cnt_q;
    logic [c_WARM_W-1:0] warm_cnt_d;
    logic                valid_q;
    logic                valid_d;
    logic                changed_q;
    logic                changed_d;
    logic [c_LOST_W-1:0] lost_cnt_q;
    logic [c_LOST_W-1:0] lost_cnt_d;
    logic                lost_q;
    logic                lost_d;
    logic                w_any_update;

    assign w_raw = {sensor_l_raw, sensor_m_raw, sensor_r_raw};

    // Two-flop synchroniser; the raw pins are used nowhere else.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: count consecutive disagreeing cycles, adopt the
    // synchronised level once the run reaches DEBOUNCE_CYCLES.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == c_DB_LAST) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + c_DB_W'(1);
                end
            end
        end
    end

    assign w_any_update = |(db_d ^ db_q);

    // Warm-up counter freezes once valid; the strobe is suppressed until the
    // cycle in which valid itself becomes visible.
    always_comb begin
        warm_cnt_d = warm_cnt_q;
        valid_d    = valid_q;
        if (!valid_q) begin
            warm_cnt_d = warm_cnt_q + c_WARM_W'(1);
            if (warm_cnt_q == c_WARM_LAST) begin
                valid_d = 1'b1;
            end
        end
        changed_d = valid_d & w_any_update;
    end

    // Lost tracking: saturating count of valid cycles spent on the lost
    // pattern; leaving the pattern clears both the count and the flag on the
    // same edge the new vector appears.
    always_comb begin
        lost_cnt_d = lost_cnt_q;
        lost_d     = 1'b0;
        if (db_d != LOST_PATTERN) begin
            lost_cnt_d = '0;
        end else begin
            if (valid_q && (db_q == LOST_PATTERN) && (lost_cnt_q != c_LOST_MAX)) begin
                lost_cnt_d = lost_cnt_q + c_LOST_W'(1);
            end
            lost_d = (lost_cnt_d == c_LOST_MAX);
        end
    end

    // State registers for debouncers, warm-up, strobe and lost tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q       <= 3'b000;
            warm_cnt_q <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            lost_cnt_q <= '0;
            lost_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q       <= db_d;
            warm_cnt_q <= warm_cnt_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            lost_cnt_q <= lost_cnt_d;
            lost_q     <= lost_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign sensor_l        = db_q[2];
    assign sensor_m        = db_q[1];
    assign sensor_r        = db_q[0];
    assign sensors_valid   = valid_q;
    assign sensors_changed = changed_q;
    assign line_lost       = lost_q;

endmodule
`default_nettype wire
